s2p_word_latch: RTL

//  Parametrised serial-to-parallel receiver. Samples an asynchronous serial stream (sin, strobed by st_clk) into
//  a WIDTH-bit shift register, counts bits within a frame and latches each complete word into a holding register.
//  A valid/ready handshake, a sticky overrun flag, a tri-state output enable and a daisy-chain serial out are provided.

---
 rtl/s2p_pkg.sv | 12 +
 rtl/s2p_sync.sv | 29 ++
 rtl/s2p_word_latch.sv | 112 +++++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// Shared helpers and constants for the serial-to-parallel word latch.
package s2p_pkg;

  localparam int ORDER_MSB_FIRST = 1;
  localparam int ORDER_LSB_FIRST = 0;

  // Width of the in-word bit counter.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/s2p_sync.sv
// N-flop synchroniser for an asynchronous level, with a one-cycle rising-edge pulse on the synced value.
module s2p_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] ff;
  logic              q_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff  <= '0;
      q_d <= 1'b0;
    end else begin
      ff  <= {ff[STAGES-2:0], d};
      q_d <= ff[STAGES-1];
    end
  end

  assign q    = ff[STAGES-1];
  assign rise = ff[STAGES-1] & ~q_d;

endmodule

// File: rtl/s2p_word_latch.sv
// Serial-to-parallel receiver: synchronised strobe/data/frame, shift register, bit counter,
// holding register with valid/ready handshake, sticky overrun, tri-state word output and daisy-chain sout.
module s2p_word_latch
  import s2p_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int MSB_FIRST   = ORDER_MSB_FIRST,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_clk,
  input  logic             sin,
  input  logic             frame_n,
  input  logic             oe_n,
  input  logic             dout_ready,
  input  logic             overrun_clr,
  output logic             sout,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun,
  output logic [CW-1:0]    bit_cnt
);

  logic             shift_en;
  logic             sin_s;
  logic             frame_n_s;
  logic             st_clk_s_unused;
  logic             sin_rise_unused;
  logic             frame_rise_unused;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] word;
  logic             out_bit;
  logic             shift;
  logic             last_bit;
  logic             complete;
  logic             accept;
  logic             drop;

  s2p_sync #(.STAGES(SYNC_STAGES)) u_sync_st (
    .clk(clk), .rst_n(rst_n), .d(st_clk), .q(st_clk_s_unused), .rise(shift_en)
  );
  s2p_sync #(.STAGES(SYNC_STAGES)) u_sync_sin (
    .clk(clk), .rst_n(rst_n), .d(sin), .q(sin_s), .rise(sin_rise_unused)
  );
  s2p_sync #(.STAGES(SYNC_STAGES)) u_sync_frame (
    .clk(clk), .rst_n(rst_n), .d(frame_n), .q(frame_n_s), .rise(frame_rise_unused)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    word    = sr;
    out_bit = 1'b0;
    if (MSB_FIRST == ORDER_MSB_FIRST) begin
      word    = {sr[WIDTH-2:0], sin_s};
      out_bit = sr[WIDTH-1];
    end else begin
      word    = {sin_s, sr[WIDTH-1:1]};
      out_bit = sr[0];
    end
  end

  assign shift    = shift_en & ~frame_n_s;
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  assign complete = shift & last_bit;
  assign accept   = complete & (~dout_valid | dout_ready);
  assign drop     = complete & dout_valid & ~dout_ready;

  // Frame inactive holds the count at zero but leaves the shift register alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      sout    <= 1'b0;
      bit_cnt <= '0;
    end else if (frame_n_s) begin
      bit_cnt <= '0;
    end else if (shift) begin
      sr      <= word;
      sout    <= out_bit;
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

  // A completion with a simultaneous read refills the register without dropping valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      dout_valid <= 1'b0;
    end else if (accept) begin
      hold       <= word;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  assign dout = oe_n ? {WIDTH{1'bz}} : hold;

endmodule
